// File: rtl/id_ex_hazard_stage_pkg.sv
// Shared definitions for the ID/EX hazard stage: FSM encoding and the x0 register index.
package id_ex_hazard_stage_pkg;

  typedef enum logic {
    RUN  = 1'b0,
    HOLD = 1'b1
  } state_t;

  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/id_ex_hazard_stage_load_use_detect.sv
// Combinational load-use hazard check: the ID instruction reads a register that the
// load currently in EX is about to write.
module load_use_detect
  import id_ex_hazard_stage_pkg::*;
(
  input  logic       i_valid_id,
  input  logic [4:0] i_rs1_id,
  input  logic [4:0] i_rs2_id,
  input  logic       i_use_rs1_id,
  input  logic       i_use_rs2_id,
  input  logic       i_valid_ex,
  input  logic       i_memread_ex,
  input  logic [4:0] i_rd_ex,
  output logic       o_hz
);

  logic w_rs1_match;
  logic w_rs2_match;

  assign w_rs1_match = i_use_rs1_id & (i_rs1_id == i_rd_ex);
  assign w_rs2_match = i_use_rs2_id & (i_rs2_id == i_rd_ex);

  // A load into x0 produces nothing worth waiting for.
  assign o_hz = i_valid_id & i_valid_ex & i_memread_ex & (i_rd_ex != REG_ZERO)
              & (w_rs1_match | w_rs2_match);

endmodule

// File: rtl/id_ex_hazard_stage.sv
// ID/EX register for the forwarding-relevant decode fields, with load-use stall
// control and a saturating stall-cycle counter.
module id_ex_hazard_stage
  import id_ex_hazard_stage_pkg::*;
#(
  parameter int LOAD_USE_BUBBLES = 1,
  parameter int CNT_W            = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_ID,
  input  logic [4:0]       Rs1_ID,
  input  logic [4:0]       Rs2_ID,
  input  logic             use_rs1_ID,
  input  logic             use_rs2_ID,
  input  logic [4:0]       Rd_ID,
  input  logic             RegWrite_ID,
  input  logic             MemRead_ID,
  input  logic             flush_EX,
  output logic [4:0]       Rs1_ID_EX,
  output logic [4:0]       Rs2_ID_EX,
  output logic [4:0]       Rd_ID_EX,
  output logic             RegWrite_ID_EX,
  output logic             MemRead_ID_EX,
  output logic             valid_EX,
  output logic             stall,
  output logic [CNT_W-1:0] stall_cycles
);

  localparam logic [1:0] HOLD_REM = 2'(LOAD_USE_BUBBLES - 1);

  state_t           r_state;
  state_t           w_state_next;
  logic [1:0]       r_rem;
  logic [1:0]       w_rem_next;
  logic             w_hz;
  logic             w_bubble;
  logic             w_stall;
  logic [4:0]       r_rs1;
  logic [4:0]       r_rs2;
  logic [4:0]       r_rd;
  logic             r_regwrite;
  logic             r_memread;
  logic             r_valid;
  logic [CNT_W-1:0] r_cnt;

  load_use_detect u_detect (
    .i_valid_id   (valid_ID),
    .i_rs1_id     (Rs1_ID),
    .i_rs2_id     (Rs2_ID),
    .i_use_rs1_id (use_rs1_ID),
    .i_use_rs2_id (use_rs2_ID),
    .i_valid_ex   (r_valid),
    .i_memread_ex (r_memread),
    .i_rd_ex      (r_rd),
    .o_hz         (w_hz)
  );

  // Flush wins over the hazard: the killed ID instruction must not delay the redirect.
  always_comb begin
    w_state_next = r_state;
    w_rem_next   = r_rem;
    w_bubble     = 1'b0;
    w_stall      = 1'b0;
    if (rst) begin
      w_state_next = RUN;
      w_rem_next   = 2'd0;
    end else if (flush_EX) begin
      w_bubble     = 1'b1;
      w_state_next = RUN;
      w_rem_next   = 2'd0;
    end else if (r_state == HOLD) begin
      w_stall    = 1'b1;
      w_bubble   = 1'b1;
      w_rem_next = r_rem - 2'd1;
      if (r_rem == 2'd1) begin
        w_state_next = RUN;
      end
    end else if (w_hz) begin
      w_stall  = 1'b1;
      w_bubble = 1'b1;
      if (LOAD_USE_BUBBLES > 1) begin
        w_state_next = HOLD;
        w_rem_next   = HOLD_REM;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= RUN;
      r_rem      <= 2'd0;
      r_rs1      <= REG_ZERO;
      r_rs2      <= REG_ZERO;
      r_rd       <= REG_ZERO;
      r_regwrite <= 1'b0;
      r_memread  <= 1'b0;
      r_valid    <= 1'b0;
      r_cnt      <= '0;
    end else begin
      r_state <= w_state_next;
      r_rem   <= w_rem_next;
      if (w_stall && (r_cnt != {CNT_W{1'b1}})) begin
        r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      end
      if (w_bubble) begin
        r_rs1      <= REG_ZERO;
        r_rs2      <= REG_ZERO;
        r_rd       <= REG_ZERO;
        r_regwrite <= 1'b0;
        r_memread  <= 1'b0;
        r_valid    <= 1'b0;
      end else begin
        r_rs1      <= Rs1_ID;
        r_rs2      <= Rs2_ID;
        r_rd       <= Rd_ID;
        // Writes to x0 are dropped here so the forwarding unit never sees them.
        r_regwrite <= RegWrite_ID & valid_ID & (Rd_ID != REG_ZERO);
        r_memread  <= MemRead_ID & valid_ID;
        r_valid    <= valid_ID;
      end
    end
  end

  assign Rs1_ID_EX      = r_rs1;
  assign Rs2_ID_EX      = r_rs2;
  assign Rd_ID_EX       = r_rd;
  assign RegWrite_ID_EX = r_regwrite;
  assign MemRead_ID_EX  = r_memread;
  assign valid_EX       = r_valid;
  assign stall          = w_stall;
  assign stall_cycles   = r_cnt;

endmodule

// File: tb/tb_id_ex_hazard_stage.sv
// Bench for id_ex_hazard_stage: three instances (1 bubble, 2 bubbles, 2-bit counter)
// driven in lock-step and checked against a cycle-level model plus directed tables.
module tb_id_ex_hazard_stage;

  localparam int N = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, valid_ID, use_rs1_ID, use_rs2_ID, RegWrite_ID, MemRead_ID, flush_EX;
  logic [4:0] Rs1_ID, Rs2_ID, Rd_ID;

  logic [4:0]  o_rs1 [N];
  logic [4:0]  o_rs2 [N];
  logic [4:0]  o_rd  [N];
  logic        o_rw  [N];
  logic        o_mr  [N];
  logic        o_v   [N];
  logic        o_stall [N];
  logic [15:0] o_cnt [N];
  logic [15:0] cnt0, cnt1;
  logic [1:0]  cnt2;

  assign o_cnt[0] = cnt0;
  assign o_cnt[1] = cnt1;
  assign o_cnt[2] = {14'd0, cnt2};

  id_ex_hazard_stage #(.LOAD_USE_BUBBLES(1), .CNT_W(16)) dut0 (
    .clk(clk), .rst(rst), .valid_ID(valid_ID), .Rs1_ID(Rs1_ID), .Rs2_ID(Rs2_ID),
    .use_rs1_ID(use_rs1_ID), .use_rs2_ID(use_rs2_ID), .Rd_ID(Rd_ID),
    .RegWrite_ID(RegWrite_ID), .MemRead_ID(MemRead_ID), .flush_EX(flush_EX),
    .Rs1_ID_EX(o_rs1[0]), .Rs2_ID_EX(o_rs2[0]), .Rd_ID_EX(o_rd[0]),
    .RegWrite_ID_EX(o_rw[0]), .MemRead_ID_EX(o_mr[0]), .valid_EX(o_v[0]),
    .stall(o_stall[0]), .stall_cycles(cnt0));

  id_ex_hazard_stage #(.LOAD_USE_BUBBLES(2), .CNT_W(16)) dut1 (
    .clk(clk), .rst(rst), .valid_ID(valid_ID), .Rs1_ID(Rs1_ID), .Rs2_ID(Rs2_ID),
    .use_rs1_ID(use_rs1_ID), .use_rs2_ID(use_rs2_ID), .Rd_ID(Rd_ID),
    .RegWrite_ID(RegWrite_ID), .MemRead_ID(MemRead_ID), .flush_EX(flush_EX),
    .Rs1_ID_EX(o_rs1[1]), .Rs2_ID_EX(o_rs2[1]), .Rd_ID_EX(o_rd[1]),
    .RegWrite_ID_EX(o_rw[1]), .MemRead_ID_EX(o_mr[1]), .valid_EX(o_v[1]),
    .stall(o_stall[1]), .stall_cycles(cnt1));

  id_ex_hazard_stage #(.LOAD_USE_BUBBLES(1), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .valid_ID(valid_ID), .Rs1_ID(Rs1_ID), .Rs2_ID(Rs2_ID),
    .use_rs1_ID(use_rs1_ID), .use_rs2_ID(use_rs2_ID), .Rd_ID(Rd_ID),
    .RegWrite_ID(RegWrite_ID), .MemRead_ID(MemRead_ID), .flush_EX(flush_EX),
    .Rs1_ID_EX(o_rs1[2]), .Rs2_ID_EX(o_rs2[2]), .Rd_ID_EX(o_rd[2]),
    .RegWrite_ID_EX(o_rw[2]), .MemRead_ID_EX(o_mr[2]), .valid_EX(o_v[2]),
    .stall(o_stall[2]), .stall_cycles(cnt2));

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference model: what EX should hold, how many extra bubbles are still owed,
  // and the expected stall count.
  typedef struct {
    logic [4:0] rs1, rs2, rd;
    logic       rw, mr, v;
  } ex_t;

  ex_t m_ex    [N];
  int  m_owed  [N];
  int  m_cnt   [N];
  bit  m_stall [N];
  bit  m_hz    [N];
  int  bub_cfg [N] = '{1, 2, 1};
  int  cnt_max [N] = '{65535, 65535, 3};
  bit  stall_seen [N];

  function automatic bit model_hz(input int i);
    bit reads_rd;
    reads_rd = (use_rs1_ID && Rs1_ID == m_ex[i].rd) || (use_rs2_ID && Rs2_ID == m_ex[i].rd);
    return valid_ID && m_ex[i].v && m_ex[i].mr && (m_ex[i].rd != 0) && reads_rd;
  endfunction

  task automatic model_edge(input int i);
    ex_t zero_ex;
    zero_ex = '{rs1: 5'd0, rs2: 5'd0, rd: 5'd0, rw: 1'b0, mr: 1'b0, v: 1'b0};
    if (rst) begin
      m_ex[i] = zero_ex; m_owed[i] = 0; m_cnt[i] = 0;
    end else begin
      if (m_stall[i]) m_cnt[i] = (m_cnt[i] + 1 > cnt_max[i]) ? cnt_max[i] : m_cnt[i] + 1;
      if (flush_EX) begin
        m_ex[i] = zero_ex; m_owed[i] = 0;
      end else if (m_owed[i] > 0) begin
        m_ex[i] = zero_ex; m_owed[i] = m_owed[i] - 1;
      end else if (m_hz[i]) begin
        m_ex[i] = zero_ex; m_owed[i] = bub_cfg[i] - 1;
      end else begin
        m_ex[i].rs1 = Rs1_ID;
        m_ex[i].rs2 = Rs2_ID;
        m_ex[i].rd  = Rd_ID;
        m_ex[i].v   = valid_ID;
        m_ex[i].rw  = RegWrite_ID && valid_ID && (Rd_ID != 0);
        m_ex[i].mr  = MemRead_ID && valid_ID;
      end
    end
  endtask

  task automatic cycle(input string tag);
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      m_hz[i]    = model_hz(i);
      m_stall[i] = !rst && !flush_EX && (m_owed[i] > 0 || m_hz[i]);
      stall_seen[i] = o_stall[i];
      chk($sformatf("%s_stall%0d", tag, i), int'(o_stall[i]), int'(m_stall[i]));
    end
    @(posedge clk);
    for (int i = 0; i < N; i++) model_edge(i);
    #1;
    for (int i = 0; i < N; i++) begin
      chk($sformatf("%s_valid%0d", tag, i), int'(o_v[i]),  int'(m_ex[i].v));
      chk($sformatf("%s_rs1_%0d", tag, i),  int'(o_rs1[i]), int'(m_ex[i].rs1));
      chk($sformatf("%s_rs2_%0d", tag, i),  int'(o_rs2[i]), int'(m_ex[i].rs2));
      chk($sformatf("%s_rd%0d", tag, i),    int'(o_rd[i]),  int'(m_ex[i].rd));
      chk($sformatf("%s_rw%0d", tag, i),    int'(o_rw[i]),  int'(m_ex[i].rw));
      chk($sformatf("%s_mr%0d", tag, i),    int'(o_mr[i]),  int'(m_ex[i].mr));
      chk($sformatf("%s_cnt%0d", tag, i),   int'(o_cnt[i]), m_cnt[i]);
    end
    $display("%s rst=%0d fl=%0d vID=%0d rs1=%0d rs2=%0d rd=%0d | stall=%0d%0d%0d vEX=%0d%0d%0d cnt=%0d/%0d/%0d",
             tag, rst, flush_EX, valid_ID, Rs1_ID, Rs2_ID, Rd_ID,
             stall_seen[0], stall_seen[1], stall_seen[2], o_v[0], o_v[1], o_v[2],
             o_cnt[0], o_cnt[1], o_cnt[2]);
  endtask

  task automatic setin(input logic v, input logic [4:0] rs1, input logic u1,
                       input logic [4:0] rs2, input logic u2, input logic [4:0] rd,
                       input logic rw, input logic mr, input logic fl);
    valid_ID = v; Rs1_ID = rs1; use_rs1_ID = u1; Rs2_ID = rs2; use_rs2_ID = u2;
    Rd_ID = rd; RegWrite_ID = rw; MemRead_ID = mr; flush_EX = fl;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    setin(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    cycle("reset");
    rst = 1'b0;
  endtask

  // Directed table for the single-bubble instance: inputs and hand-derived results.
  typedef struct {
    logic       v, u1, u2, rw, mr, fl;
    logic [4:0] rs1, rs2, rd;
    logic       e_stall, e_v, e_rw, e_mr;
    logic [4:0] e_rs1, e_rd;
  } vec_t;

  function automatic vec_t mk(input logic v, input logic [4:0] rs1, input logic u1,
                              input logic [4:0] rs2, input logic u2, input logic [4:0] rd,
                              input logic rw, input logic mr, input logic fl,
                              input logic e_stall, input logic e_v, input logic [4:0] e_rs1,
                              input logic [4:0] e_rd, input logic e_rw, input logic e_mr);
    vec_t t;
    t.v = v; t.rs1 = rs1; t.u1 = u1; t.rs2 = rs2; t.u2 = u2; t.rd = rd;
    t.rw = rw; t.mr = mr; t.fl = fl;
    t.e_stall = e_stall; t.e_v = e_v; t.e_rs1 = e_rs1; t.e_rd = e_rd;
    t.e_rw = e_rw; t.e_mr = e_mr;
    return t;
  endfunction

  vec_t tbl [16];

  initial begin
    tbl[0]  = mk(1,  1, 1,  0, 0,  5, 1, 1, 0,   0, 1,  1,  5, 1, 1); // lw x5
    tbl[1]  = mk(1,  5, 1,  7, 1,  6, 1, 0, 0,   1, 0,  0,  0, 0, 0); // add x6,x5,x7 -> bubble
    tbl[2]  = mk(1,  5, 1,  7, 1,  6, 1, 0, 0,   0, 1,  5,  6, 1, 0); // add captured
    tbl[3]  = mk(1,  3, 1,  0, 0,  0, 1, 1, 0,   0, 1,  3,  0, 0, 1); // lw x0: no RegWrite
    tbl[4]  = mk(1,  0, 1,  0, 1,  1, 1, 0, 0,   0, 1,  0,  1, 1, 0); // reads x0: no stall
    tbl[5]  = mk(0,  9, 1,  0, 0,  4, 1, 1, 0,   0, 0,  9,  4, 0, 0); // invalid ID
    tbl[6]  = mk(1,  2, 1,  0, 0,  8, 1, 1, 0,   0, 1,  2,  8, 1, 1); // lw x8
    tbl[7]  = mk(1,  8, 0,  3, 1,  9, 1, 0, 0,   0, 1,  8,  9, 1, 0); // x8 in rs1 but unused
    tbl[8]  = mk(1,  1, 1,  0, 0, 10, 1, 1, 0,   0, 1,  1, 10, 1, 1); // lw x10
    tbl[9]  = mk(1,  0, 1, 10, 1, 11, 1, 0, 1,   0, 0,  0,  0, 0, 0); // hazard + flush
    tbl[10] = mk(1,  0, 1, 10, 1, 11, 1, 0, 0,   0, 1,  0, 11, 1, 0); // after flush: capture
    tbl[11] = mk(1,  1, 1,  0, 0, 12, 1, 1, 0,   0, 1,  1, 12, 1, 1); // lw x12
    tbl[12] = mk(0, 12, 1,  0, 0, 13, 1, 0, 0,   0, 0, 12, 13, 0, 0); // invalid reader
    tbl[13] = mk(1,  1, 1,  0, 0, 14, 1, 1, 0,   0, 1,  1, 14, 1, 1); // lw x14
    tbl[14] = mk(1,  2, 1, 14, 1, 15, 1, 0, 0,   1, 0,  0,  0, 0, 0); // rs2 hazard
    tbl[15] = mk(1,  2, 1, 14, 1, 15, 1, 0, 0,   0, 1,  2, 15, 1, 0);
  end

  initial begin
    for (int i = 0; i < N; i++) begin
      m_ex[i] = '{rs1: 5'd0, rs2: 5'd0, rd: 5'd0, rw: 1'b0, mr: 1'b0, v: 1'b0};
      m_owed[i] = 0; m_cnt[i] = 0;
    end
    rst = 1'b1;
    setin(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    cycle("reset");
    cycle("reset");
    for (int i = 0; i < N; i++) begin
      chk($sformatf("reset_valid%0d", i), int'(o_v[i]), 0);
      chk($sformatf("reset_cnt%0d", i), int'(o_cnt[i]), 0);
    end
    rst = 1'b0;

    // Directed table
    for (int k = 0; k < 16; k++) begin
      setin(tbl[k].v, tbl[k].rs1, tbl[k].u1, tbl[k].rs2, tbl[k].u2, tbl[k].rd,
            tbl[k].rw, tbl[k].mr, tbl[k].fl);
      cycle($sformatf("tbl%0d", k));
      chk($sformatf("tbl%0d_stall", k), int'(stall_seen[0]), int'(tbl[k].e_stall));
      chk($sformatf("tbl%0d_valid", k), int'(o_v[0]), int'(tbl[k].e_v));
      chk($sformatf("tbl%0d_rs1", k), int'(o_rs1[0]), int'(tbl[k].e_rs1));
      chk($sformatf("tbl%0d_rd", k), int'(o_rd[0]), int'(tbl[k].e_rd));
      chk($sformatf("tbl%0d_rw", k), int'(o_rw[0]), int'(tbl[k].e_rw));
      chk($sformatf("tbl%0d_mr", k), int'(o_mr[0]), int'(tbl[k].e_mr));
    end
    chk("tbl_cnt0", int'(o_cnt[0]), 2);

    // Two-bubble load-use: two stall cycles, two bubbles, counter +2
    do_reset();
    setin(1, 1, 1, 0, 0, 5, 1, 1, 0); cycle("dbl_lw");
    setin(1, 5, 1, 7, 1, 6, 1, 0, 0); cycle("dbl_a");
    chk("dbl_stall_a", int'(stall_seen[1]), 1);
    chk("dbl_bubble_a", int'(o_v[1]), 0);
    cycle("dbl_b");
    chk("dbl_stall_b", int'(stall_seen[1]), 1);
    chk("dbl_bubble_b", int'(o_v[1]), 0);
    cycle("dbl_c");
    chk("dbl_stall_c", int'(stall_seen[1]), 0);
    chk("dbl_capture_v", int'(o_v[1]), 1);
    chk("dbl_capture_rs1", int'(o_rs1[1]), 5);
    chk("dbl_cnt", int'(o_cnt[1]), 2);

    // Reset while the two-bubble instance is holding
    do_reset();
    setin(1, 1, 1, 0, 0, 5, 1, 1, 0); cycle("rsth_lw");
    setin(1, 5, 1, 7, 1, 6, 1, 0, 0); cycle("rsth_hz");
    rst = 1'b1; cycle("rsth_rst");
    chk("rsth_stall", int'(stall_seen[1]), 0);
    chk("rsth_valid", int'(o_v[1]), 0);
    chk("rsth_rs1", int'(o_rs1[1]), 0);
    chk("rsth_cnt", int'(o_cnt[1]), 0);
    rst = 1'b0; cycle("rsth_after");
    chk("rsth_after_stall", int'(stall_seen[1]), 0);

    // Five load-use stalls: the 2-bit counter saturates at 3
    do_reset();
    for (int k = 0; k < 5; k++) begin
      setin(1, 1, 1, 0, 0, 5, 1, 1, 0); cycle("sat_lw");
      setin(1, 5, 1, 7, 1, 6, 1, 0, 0); cycle("sat_hz"); cycle("sat_cap");
    end
    chk("sat_cnt2", int'(o_cnt[2]), 3);
    chk("sat_cnt0", int'(o_cnt[0]), 5);

    // Randomized traffic with a small register set so hazards are frequent
    for (int k = 0; k < 600; k++) begin
      rst = ($urandom_range(0, 49) == 0);
      setin(($urandom_range(0, 9) != 0), 5'($urandom_range(0, 3)), 1'($urandom),
            5'($urandom_range(0, 3)), 1'($urandom), 5'($urandom_range(0, 3)),
            1'($urandom), 1'($urandom), ($urandom_range(0, 7) == 0));
      cycle($sformatf("rnd%0d", k));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
